fetch_unit: RTL and testbench

- Instruction fetch stage of the MIPS core; directly upstream of the control unit.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Presents the fetched word with its PC and PC+4; opcode = instr[31:26], funct = instr[5:0] go to decode/control.
- Applies the next-PC decision (sequential or redirect) when the downstream stage accepts the instruction.

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS instruction fetch stage: PC, imem req/ack handshake, next-PC select.
// Optional target alignment fault checking is enabled with FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_ERR} state_t;
`else
    typedef enum logic [1:0] {ST_FETCH, ST_HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] target_pc;

    assign target_pc = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            instr_q <= 32'h0000_0000;
            ipc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        case (state_q)
            ST_FETCH: begin
                req_d = 1'b1;
                // An ack only counts against a request that is actually on the bus.
                if (req_q && imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    req_d   = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                req_d = 1'b0;
                if (instr_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                        state_d = ST_ERR;
                    end else begin
                        pc_d    = target_pc;
                        req_d   = 1'b1;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = target_pc;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
`endif
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase
    end

    assign imem_req       = req_q;
    assign imem_addr      = pc_q;
    assign instr          = instr_q;
    assign instr_pc       = ipc_q;
    assign instr_pc_plus4 = ipc_q + 32'd4;
    assign instr_valid    = (state_q == ST_HOLD);
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_err   = (state_q == ST_ERR);
`else
    assign misalign_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit (RESET_PC=0x40).
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pc_plus4(instr_pc_plus4),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic rv, input logic [31:0] rpc,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_instr, input logic [31:0] e_pc,
                       input logic [31:0] e_p4, input logic e_err);
        vec_t v;
        v = '{ack, rdata, ready, rv, rpc, e_req, e_addr, e_valid, e_instr, e_pc, e_p4, e_err};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        // ack rdata ready rv rpc | req addr valid instr pc p4 err
        add(0, 32'h0,         0, 0, 32'h0,         1, 32'h40,        0, 32'h0,         32'h0,         32'h0,        0);
        add(1, 32'h2008_0005, 0, 0, 32'h0,         0, 32'h40,        1, 32'h2008_0005, 32'h40,        32'h44,       0);
        add(0, 32'h0,         0, 0, 32'h0,         0, 32'h40,        1, 32'h2008_0005, 32'h40,        32'h44,       0);
        add(0, 32'h0,         0, 1, 32'h200,       0, 32'h40,        1, 32'h2008_0005, 32'h40,        32'h44,       0);
        add(1, 32'h0,         0, 0, 32'h0,         0, 32'h40,        1, 32'h2008_0005, 32'h40,        32'h44,       0);
        add(0, 32'h0,         1, 0, 32'h0,         1, 32'h44,        0, 32'h0,         32'h0,         32'h0,        0);
        add(1, 32'h2108_0001, 0, 0, 32'h0,         0, 32'h44,        1, 32'h2108_0001, 32'h44,        32'h48,       0);
        add(0, 32'h0,         1, 0, 32'h0,         1, 32'h48,        0, 32'h0,         32'h0,         32'h0,        0);
        add(1, 32'h0800_0040, 0, 0, 32'h0,         0, 32'h48,        1, 32'h0800_0040, 32'h48,        32'h4C,       0);
        add(0, 32'h0,         1, 1, 32'h100,       1, 32'h100,       0, 32'h0,         32'h0,         32'h0,        0);
        add(0, 32'h0,         0, 1, 32'h300,       1, 32'h100,       0, 32'h0,         32'h0,         32'h0,        0);
        add(1, 32'h0000_0011, 0, 1, 32'h300,       0, 32'h100,       1, 32'h0000_0011, 32'h100,       32'h104,      0);
        add(0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         32'h0,        0);
        add(0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         32'h0,        0);
        add(0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0,         32'h0,         32'h0,        0);
        add(1, 32'h0000_00AB, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h0000_00AB, 32'hFFFF_FFFC, 32'h0,        0);
        add(0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         32'h0,        0);
        add(1, 32'h0000_0022, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0022, 32'h0,         32'h4,        0);
        add(1, 32'h0000_0099, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0022, 32'h0,         32'h4,        0);
`ifdef FETCH_ALIGN_CHECK_EN
        add(0, 32'h0,         1, 1, 32'h102,       0, 32'h0,         0, 32'h0,         32'h0,         32'h0,        1);
        add(1, 32'h0000_0033, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         32'h0,        1);
        add(0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         32'h0,        1);
`else
        add(0, 32'h0,         1, 1, 32'h102,       1, 32'h100,       0, 32'h0,         32'h0,         32'h0,        0);
        add(1, 32'h0000_0033, 0, 0, 32'h0,         0, 32'h100,       1, 32'h0000_0033, 32'h100,       32'h104,      0);
`endif

        // Reset state while rst is held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   {31'h0, imem_req},     32'h0);
        chk("rst_addr",  imem_addr,             32'h40);
        chk("rst_valid", {31'h0, instr_valid},  32'h0);
        chk("rst_instr", instr,                 32'h0);
        chk("rst_pc",    instr_pc,              32'h40);
        chk("rst_p4",    instr_pc_plus4,        32'h44);
        chk("rst_err",   {31'h0, misalign_err}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            imem_ack       = vq[i].ack;
            imem_rdata     = vq[i].rdata;
            instr_ready    = vq[i].ready;
            redirect_valid = vq[i].rv;
            redirect_pc    = vq[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_req", i),   {31'h0, imem_req},     {31'h0, vq[i].e_req});
            chk($sformatf("v%0d_addr", i),  imem_addr,             vq[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'h0, instr_valid},  {31'h0, vq[i].e_valid});
            chk($sformatf("v%0d_err", i),   {31'h0, misalign_err}, {31'h0, vq[i].e_err});
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d_instr", i), instr,          vq[i].e_instr);
                chk($sformatf("v%0d_pc", i),    instr_pc,       vq[i].e_pc);
                chk($sformatf("v%0d_p4", i),    instr_pc_plus4, vq[i].e_p4);
            end
            @(negedge clk);
        end

        // Async reset mid-fetch, then a late ack after release
        imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mf_req_up",  {31'h0, imem_req}, 32'h1);
        chk("mf_addr",    imem_addr,         32'h40);
        #2;
        rst = 1'b1;
        #1;
        chk("mf_req_drop", {31'h0, imem_req},    32'h0);
        chk("mf_valid",    {31'h0, instr_valid}, 32'h0);
        chk("mf_err",      {31'h0, misalign_err}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_DEAD;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("late_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("late_ack_req",   {31'h0, imem_req},    32'h1);
        @(posedge clk);
        #1;
        chk("restart_valid", {31'h0, instr_valid}, 32'h1);
        chk("restart_instr", instr,                32'h0000_DEAD);
        chk("restart_pc",    instr_pc,             32'h40);

        // Async reset while holding an instruction
        imem_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("hold_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("hold_rst_instr", instr,                32'h0);
        chk("hold_rst_req",   {31'h0, imem_req},    32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_rst_refetch", {31'h0, imem_req}, 32'h1);
        chk("hold_rst_addr",    imem_addr,         32'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
